// File: rtl/wb_irq_logger_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// wb_irq_logger_if : Wishbone classic register port of the interrupt logger.
// Revision 1.0
//------------------------------------------------------------------------------
interface wb_irq_logger_if;
    logic       i_wb_cyc;
    logic       i_wb_stb;
    logic       i_wb_we;
    logic [3:0] i_wb_addr;
    logic [7:0] i_wb_data;
    logic [7:0] o_wb_data;
    logic       o_wb_ack;

    modport master (
        output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data,
        input  o_wb_data, o_wb_ack
    );

    modport slave (
        input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data,
        output o_wb_data, o_wb_ack
    );
endinterface
`default_nettype wire

// File: rtl/wb_irq_logger.sv
`default_nettype none
//------------------------------------------------------------------------------
// wb_irq_logger : timestamps edges of an async active-low IRQ into a FIFO,
//                 readable over a Wishbone classic register port.
// Revision 1.0
//------------------------------------------------------------------------------
module wb_irq_logger #(
    parameter int TS_WIDTH   = 23,
    parameter int FIFO_DEPTH = 8
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    wb_irq_logger_if.slave wb,
    input  logic           i_irq_n,
    output logic           o_irq
);
    localparam int         PW       = $clog2(FIFO_DEPTH);
    localparam logic [3:0] C_DEPTH  = 4'(FIFO_DEPTH);
    localparam logic [7:0] C_ID     = 8'hC5;
    localparam logic [3:0] C_A_CTRL = 4'h0;
    localparam logic [3:0] C_A_STAT = 4'h1;
    localparam logic [3:0] C_A_HD0  = 4'h2;
    localparam logic [3:0] C_A_HD1  = 4'h3;
    localparam logic [3:0] C_A_HD2  = 4'h4;
    localparam logic [3:0] C_A_POP  = 4'h5;
    localparam logic [3:0] C_A_SCR  = 4'h6;
    localparam logic [3:0] C_A_ID   = 4'h7;

    logic                r_s1;
    logic                r_s2;
    logic                r_s3;
    logic [TS_WIDTH-1:0] r_ts;
    logic                r_en;
    logic                r_both;
    logic                r_ovf;
    logic [7:0]          r_scratch;
    logic                r_ack;
    logic [7:0]          r_rdata;
    logic [23:0]         r_mem [FIFO_DEPTH];
    logic [PW-1:0]       r_rd_ptr;
    logic [PW-1:0]       r_wr_ptr;
    logic [3:0]          r_count;

    logic                w_req;
    logic                w_wr;
    logic                w_rd;
    logic                w_ctrl_wr;
    logic                w_clear;
    logic                w_stat_wr;
    logic                w_pop_wr;
    logic                w_scr_wr;
    logic                w_empty;
    logic                w_full;
    logic                w_change;
    logic                w_fall;
    logic                w_event;
    logic                w_pop;
    logic                w_push;
    logic                w_ovf_set;
    logic [22:0]         w_ts_ext;
    logic [23:0]         w_entry;
    logic [23:0]         w_head;
    logic [7:0]          w_rdata;

    // Bus decode: a strobe still high during its own ack cycle is not a new request
    assign w_req     = wb.i_wb_cyc & wb.i_wb_stb & ~r_ack;
    assign w_wr      = w_req & wb.i_wb_we;
    assign w_rd      = w_req & ~wb.i_wb_we;
    assign w_ctrl_wr = w_wr & (wb.i_wb_addr == C_A_CTRL);
    assign w_clear   = w_ctrl_wr & wb.i_wb_data[7];
    assign w_stat_wr = w_wr & (wb.i_wb_addr == C_A_STAT);
    assign w_pop_wr  = w_wr & (wb.i_wb_addr == C_A_POP);
    assign w_scr_wr  = w_wr & (wb.i_wb_addr == C_A_SCR);

    assign w_empty   = (r_count == 4'd0);
    assign w_full    = (r_count == C_DEPTH);

    assign w_change  = r_s2 ^ r_s3;
    assign w_fall    = r_s3 & ~r_s2;
    assign w_event   = r_en & (w_fall | (r_both & w_change));

    // A pop frees the slot the coincident push needs, so a full FIFO still accepts it
    assign w_pop     = w_pop_wr & ~w_empty;
    assign w_push    = w_event & ~w_clear & (~w_full | w_pop);
    assign w_ovf_set = w_event & ~w_clear & w_full & ~w_pop;

    assign w_ts_ext  = 23'(r_ts);
    assign w_entry   = {r_s2, w_ts_ext};
    assign w_head    = w_empty ? 24'h000000 : r_mem[r_rd_ptr];

    assign o_irq        = r_en & ~w_empty;
    assign wb.o_wb_ack  = r_ack;
    assign wb.o_wb_data = r_rdata;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_s1 <= 1'b1;
            r_s2 <= 1'b1;
            r_s3 <= 1'b1;
        end else begin
            r_s1 <= i_irq_n;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_ts <= '0;
        end else begin
            r_ts <= r_ts + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_en      <= 1'b0;
            r_both    <= 1'b0;
            r_scratch <= 8'h00;
        end else begin
            if (w_ctrl_wr) begin
                r_en   <= wb.i_wb_data[0];
                r_both <= wb.i_wb_data[1];
            end
            if (w_scr_wr) begin
                r_scratch <= wb.i_wb_data;
            end
        end
    end

    // A dropped event in the same cycle as a write-1-to-clear leaves overflow set
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_clear) begin
            r_ovf <= 1'b0;
        end else if (w_ovf_set) begin
            r_ovf <= 1'b1;
        end else if (w_stat_wr && wb.i_wb_data[6]) begin
            r_ovf <= 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || w_clear) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= 4'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 4'd1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 4'd1;
            end
        end
    end

    always_comb begin
        w_rdata = 8'h00;
        case (wb.i_wb_addr)
            C_A_CTRL: w_rdata = {6'b000000, r_both, r_en};
            C_A_STAT: w_rdata = {1'b0, r_ovf, w_full, w_empty, r_count};
            C_A_HD0:  w_rdata = w_head[7:0];
            C_A_HD1:  w_rdata = w_head[15:8];
            C_A_HD2:  w_rdata = w_head[23:16];
            C_A_SCR:  w_rdata = r_scratch;
            C_A_ID:   w_rdata = C_ID;
            default:  w_rdata = 8'h00;
        endcase
    end

    // Read data is captured on the request edge and held only for the ack cycle
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_ack   <= 1'b0;
            r_rdata <= 8'h00;
        end else begin
            r_ack   <= w_req;
            r_rdata <= w_rd ? w_rdata : 8'h00;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_wb_irq_logger.sv
`default_nettype none
//------------------------------------------------------------------------------
// tb_wb_irq_logger : vector table, directed corner sequences and random traffic
//                    checked against a queue-based reference model.
// Revision 1.0
//------------------------------------------------------------------------------
module tb_wb_irq_logger;
    localparam int TSW   = 8;
    localparam int DEPTH = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic irq_n = 1'b1;
    logic o_irq;

    wb_irq_logger_if bus ();

    wb_irq_logger #(.TS_WIDTH(TSW), .FIFO_DEPTH(DEPTH)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .wb      (bus.slave),
        .i_irq_n (irq_n),
        .o_irq   (o_irq)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [23:0] m_q[$];
    bit          m_ovf, m_en, m_both, m_ack;
    logic [7:0]  m_scr, m_rd;
    int          m_ts;
    logic [2:0]  m_seen;   // last three sampled irq_n values, [0] newest

    typedef struct {
        bit         we;
        logic [3:0] addr;
        logic [7:0] wd;
        logic [7:0] exp;
    } vec_t;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] m_reg(input logic [3:0] a);
        logic [23:0] h;
        h = (m_q.size() > 0) ? m_q[0] : 24'h0;
        case (a)
            4'h0:    return {6'b0, m_both, m_en};
            4'h1:    return {1'b0, m_ovf, m_q.size() == DEPTH, m_q.size() == 0, 4'(m_q.size())};
            4'h2:    return h[7:0];
            4'h3:    return h[15:8];
            4'h4:    return h[23:16];
            4'h6:    return m_scr;
            4'h7:    return 8'hC5;
            default: return 8'h00;
        endcase
    endfunction

    task automatic tick();
        bit         r, req, we, qual;
        logic [3:0] a;
        logic [7:0] d, rd;
        logic       s;
        r   = rst_n;
        we  = bus.i_wb_we;
        a   = bus.i_wb_addr;
        d   = bus.i_wb_data;
        s   = irq_n;
        req = bus.i_wb_cyc && bus.i_wb_stb && !m_ack;
        @(posedge clk);
        if (!r) begin
            m_q.delete();
            m_ovf = 0; m_en = 0; m_both = 0; m_ack = 0;
            m_scr = 8'h00; m_rd = 8'h00; m_ts = 0; m_seen = 3'b111;
        end else begin
            qual = m_en && ((m_seen[2] && !m_seen[1]) || (m_both && (m_seen[1] != m_seen[2])));
            rd   = (req && !we) ? m_reg(a) : 8'h00;
            if (req && we && a == 4'h0 && d[7]) begin
                m_q.delete();
                m_ovf = 0;
            end else begin
                if (req && we && a == 4'h1 && d[6]) m_ovf = 0;
                if (req && we && a == 4'h5 && m_q.size() > 0) void'(m_q.pop_front());
                if (qual) begin
                    if (m_q.size() < DEPTH) m_q.push_back({m_seen[1], 23'(m_ts)});
                    else                    m_ovf = 1;
                end
            end
            if (req && we && a == 4'h0) begin
                m_en   = d[0];
                m_both = d[1];
            end
            if (req && we && a == 4'h6) m_scr = d;
            m_ack  = req;
            m_rd   = rd;
            m_ts   = (m_ts + 1) % (1 << TSW);
            m_seen = {m_seen[1:0], s};
        end
        #2;
        check("ack", bus.o_wb_ack, m_ack);
        check("rdata", bus.o_wb_data, m_rd);
        check("irq", o_irq, m_en && m_q.size() > 0);
    endtask

    // Strobe is held through the ack cycle, as a classic master would
    task automatic access(input bit we, input logic [3:0] a, input logic [7:0] d,
                          output logic [7:0] rd);
        bus.i_wb_cyc  = 1'b1;
        bus.i_wb_stb  = 1'b1;
        bus.i_wb_we   = we;
        bus.i_wb_addr = a;
        bus.i_wb_data = d;
        tick();
        rd = bus.o_wb_data;
        tick();
        bus.i_wb_cyc = 1'b0;
        bus.i_wb_stb = 1'b0;
        bus.i_wb_we  = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        vec_t        tbl[18];
        logic [7:0]  rd, wd;
        logic [23:0] exp_tail;

        tbl[0]  = '{0, 4'h7, 8'h00, 8'hC5};
        tbl[1]  = '{0, 4'h1, 8'h00, 8'h10};
        tbl[2]  = '{0, 4'h0, 8'h00, 8'h00};
        tbl[3]  = '{1, 4'h6, 8'hA5, 8'h00};
        tbl[4]  = '{0, 4'h6, 8'h00, 8'hA5};
        tbl[5]  = '{0, 4'h2, 8'h00, 8'h00};
        tbl[6]  = '{0, 4'h3, 8'h00, 8'h00};
        tbl[7]  = '{0, 4'h4, 8'h00, 8'h00};
        tbl[8]  = '{1, 4'h5, 8'h00, 8'h00};
        tbl[9]  = '{0, 4'h1, 8'h00, 8'h10};
        tbl[10] = '{1, 4'hF, 8'hFF, 8'h00};
        tbl[11] = '{0, 4'hF, 8'h00, 8'h00};
        tbl[12] = '{1, 4'h7, 8'h00, 8'h00};
        tbl[13] = '{0, 4'h7, 8'h00, 8'hC5};
        tbl[14] = '{1, 4'h0, 8'h02, 8'h00};
        tbl[15] = '{0, 4'h0, 8'h00, 8'h02};
        tbl[16] = '{1, 4'h0, 8'h00, 8'h00};
        tbl[17] = '{0, 4'h8, 8'h00, 8'h00};

        bus.i_wb_cyc = 0; bus.i_wb_stb = 0; bus.i_wb_we = 0;
        bus.i_wb_addr = 0; bus.i_wb_data = 0;
        rst_n = 0;
        ticks(3);
        rst_n = 1;
        tick();

        foreach (tbl[i]) begin
            access(tbl[i].we, tbl[i].addr, tbl[i].wd, rd);
            check($sformatf("tbl[%0d]", i), rd, tbl[i].exp);
        end

        // Single falling pulse, fall-only mode
        access(1, 4'h0, 8'h01, rd);
        irq_n = 0;
        tick();
        tick();
        check("irq_latency_k1", o_irq, 0);
        tick();
        check("irq_latency_k2", o_irq, 1);
        ticks(3);
        irq_n = 1;
        ticks(4);
        access(0, 4'h1, 8'h00, rd); check("pulse_status", rd, 8'h01);
        access(0, 4'h4, 8'h00, rd); check("pulse_level", rd, 8'h00);
        access(1, 4'h5, 8'h00, rd);
        access(0, 4'h1, 8'h00, rd); check("pulse_popped", rd, 8'h10);

        // Both edges, overflow the FIFO by one
        access(1, 4'h0, 8'h03, rd);
        for (int i = 0; i < 9; i++) begin
            irq_n = ~irq_n;
            ticks(2);
        end
        ticks(3);
        access(0, 4'h1, 8'h00, rd); check("ovf_status", rd, 8'h68);
        access(1, 4'h1, 8'h40, rd);
        access(0, 4'h1, 8'h00, rd); check("ovf_cleared", rd, 8'h28);

        // Pop coincident with detection while full
        irq_n = 1;
        ticks(2);
        access(1, 4'h5, 8'h00, rd);
        ticks(2);
        access(0, 4'h1, 8'h00, rd); check("full_pushpop", rd, 8'h28);
        exp_tail = m_q[DEPTH-1];
        for (int i = 0; i < DEPTH - 1; i++) access(1, 4'h5, 8'h00, rd);
        access(0, 4'h4, 8'h00, rd); check("tail_level", rd[7], 1);
        access(0, 4'h2, 8'h00, rd); check("tail_ts", rd, exp_tail[7:0]);
        access(1, 4'h5, 8'h00, rd);
        access(0, 4'h1, 8'h00, rd); check("drained", rd, 8'h10);

        // Timestamp wrap: detections at counter 255 and 257
        for (int i = 0; i < 300 && m_ts != 253; i++) tick();
        irq_n = 0;
        ticks(2);
        irq_n = 1;
        ticks(3);
        access(0, 4'h2, 8'h00, rd); check("wrap_ts0", rd, 8'hFF);
        access(0, 4'h4, 8'h00, rd); check("wrap_lvl0", rd, 8'h00);
        access(1, 4'h5, 8'h00, rd);
        access(0, 4'h2, 8'h00, rd); check("wrap_ts1", rd, 8'h01);
        access(0, 4'h4, 8'h00, rd); check("wrap_lvl1", rd, 8'h80);
        access(1, 4'h5, 8'h00, rd);

        // Clear coincident with an event discards both old contents and the event
        access(1, 4'h0, 8'h01, rd);
        irq_n = 0; ticks(4);
        irq_n = 1; ticks(3);
        irq_n = 0; ticks(2);
        access(1, 4'h0, 8'h81, rd);
        ticks(2);
        access(0, 4'h1, 8'h00, rd); check("clear_status", rd, 8'h10);
        check("clear_irq", o_irq, 0);
        access(0, 4'h0, 8'h00, rd); check("clear_ctrl", rd, 8'h01);
        irq_n = 1;
        ticks(3);

        // Reset during a request aborts it
        bus.i_wb_cyc = 1; bus.i_wb_stb = 1; bus.i_wb_we = 1;
        bus.i_wb_addr = 4'h6; bus.i_wb_data = 8'h5A;
        rst_n = 0;
        tick();
        check("abort_ack0", bus.o_wb_ack, 0);
        rst_n = 1;
        bus.i_wb_cyc = 0; bus.i_wb_stb = 0; bus.i_wb_we = 0;
        tick();
        check("abort_ack1", bus.o_wb_ack, 0);
        access(0, 4'h6, 8'h00, rd); check("abort_scratch", rd, 8'h00);
        access(0, 4'h1, 8'h00, rd); check("abort_status", rd, 8'h10);

        // Random traffic against the model
        access(1, 4'h0, 8'h03, rd);
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(3) == 0) irq_n = ~irq_n;
            if ($urandom_range(2) == 0) begin
                logic [3:0] a;
                bit         we;
                a  = 4'($urandom_range(15));
                we = 1'($urandom_range(1));
                wd = 8'($urandom);
                if (we && a == 4'h0) begin
                    wd[7] = ($urandom_range(7) == 0);
                    wd[0] = ($urandom_range(3) != 0);
                end
                access(we, a, wd, rd);
            end else begin
                tick();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/wb_irq_logger.md
WB_IRQ_LOGGER -- requirements
Module: wb_irq_logger

Interface
REQ-001 Parameter TS_WIDTH, 23: width of the free-running timestamp counter; legal range 8..23.
REQ-002 Parameter FIFO_DEPTH, 8: event FIFO entries; power of two, 2..8.
REQ-003 i_clk  input  1  single clock for all logic.
REQ-004 i_rst_n  input  1  reset; synchronous, active-low.
REQ-005 i_wb_cyc  input  1  Wishbone classic cycle.
REQ-006 i_wb_stb  input  1  Wishbone strobe.
REQ-007 i_wb_we  input  1  write enable.
REQ-008 i_wb_addr  input  4  register byte address.
REQ-009 i_wb_data  input  8  write data.
REQ-010 o_wb_data  output  8  read data; valid only while o_wb_ack=1, otherwise 0x00.
REQ-011 o_wb_ack  output  1  single-cycle acknowledge.
REQ-012 i_irq_n  input  1  active-low interrupt from the CAN core; asynchronous to i_clk.
REQ-013 o_irq  output  1  high while CTRL.en=1 and the FIFO is non-empty.

Function
REQ-014 The block SHALL be a Wishbone classic responder: request = i_wb_cyc & i_wb_stb & !o_wb_ack; o_wb_ack SHALL rise the cycle after a request and stay high exactly one cycle.
REQ-015 A strobe held through the ack cycle SHALL NOT be re-acknowledged; each access takes 2 cycles minimum.
REQ-016 Register side effects and o_wb_data capture SHALL occur on the request cycle edge, with data driven during the ack cycle.
REQ-017 Register map: 0x0 CTRL RW (bit0 en, bit1 both-edges, bit7 clear, write-1 self-clearing, reads 0); 0x1 STATUS (bits[3:0] count, bit4 empty, bit5 full, bit6 overflow sticky, writing 1 to bit6 clears it); 0x2/0x3/0x4 HEAD bytes 0/1/2 RO; 0x5 POP, any write pops one entry, reads 0; 0x6 SCRATCH RW; 0x7 ID RO = 0xC5; 0x8-0xF read 0x00, writes ignored.
REQ-018 i_irq_n SHALL pass a 2-flop synchronizer (s1, s2) plus history flop s3; an event is detected in the cycle s2 != s3.
REQ-019 Event qualification: en=1 and (s2 falling, or both-edges=1 and any change); otherwise no push.
REQ-020 A pushed entry SHALL be 24 bits: [TS_WIDTH-1:0] = timestamp counter value in the detection cycle, zero-extended to bit 22; bit 23 = s2 (new level).
REQ-021 HEAD bytes SHALL show the oldest entry (byte2 bit7 = level); when empty they read 0x00.
REQ-022 Latency: i_irq_n change sampled at edge k -> detection at k+1 -> STATUS.count and o_irq updated from edge k+2.
REQ-023 The timestamp counter SHALL increment every cycle and wrap from 2^TS_WIDTH-1 to 0.
REQ-024 Push while full (no simultaneous pop) SHALL drop the event and set overflow.
REQ-025 Push and pop in the same cycle SHALL both take effect, count unchanged, no overflow, even when full.
REQ-026 Pop while empty SHALL be ignored; no state change.
REQ-027 Clear SHALL empty the FIFO and overflow; a same-cycle push is discarded; the timestamp counter is not affected.
REQ-028 Clearing en SHALL keep FIFO contents; only new pushes and o_irq are suppressed.

Reset
REQ-029 While i_rst_n=0 at an edge: o_wb_ack=0, o_wb_data=0x00, CTRL=0x00, SCRATCH=0x00, FIFO empty, overflow=0, counter=0, s1/s2/s3=1 (inactive, no spurious event on release), o_irq=0.
REQ-030 Reset asserted mid-access SHALL abort it: no ack the following cycle, no register effect.

Verification
REQ-031 Post-reset read 0x7 -> ack exactly 1 cycle after stb, data 0xC5; read 0x1 -> 0x10.
REQ-032 Write CTRL=0x01, pulse i_irq_n low 5 cycles -> one entry, STATUS=0x01, o_irq=1 two edges after the sampled fall; HEAD2 bit7=0.
REQ-033 CTRL=0x03, 9 toggles with depth 8 -> STATUS=0x68 (count 8, full, overflow); write 0x40 to 0x1 -> STATUS=0x28.
REQ-034 Full FIFO, POP write coincident with event detection -> count stays 8, overflow stays 0, new entry at tail.
REQ-035 Counter preloaded near wrap (TS_WIDTH=8, event at cycle 255 then 257) -> HEAD0 values 0xFF then 0x01 across pops.
REQ-036 Write CTRL=0x81 coincident with an event -> STATUS=0x10, o_irq=0; SCRATCH write 0xA5 reads back 0xA5.
